// File: rtl/fetch_unit_pkg.sv
// Shared widths, PC step, FSM encoding and queue entry layout for the fetch unit.
package fetch_unit_pkg;

  localparam int ADDR_LEN = 32;
  localparam int DATA_LEN = 32;
  localparam logic [ADDR_LEN-1:0] PC_STEP = 32'd4;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_LEN-1:0] pc;
    logic [DATA_LEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [ADDR_LEN-1:0] word_align(input logic [ADDR_LEN-1:0] a);
    return {a[ADDR_LEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_queue.sv
// Synchronous FIFO of fetched {pc, inst} entries; output comes straight from storage
// flops so a push is never visible before the following cycle.
module fetch_queue #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic                        do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // A full queue still accepts a push when the head leaves in the same cycle.
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign valid = (count_q != '0);
  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited sequential fetch into a small queue,
// with redirect flushing and dropping of responses still in flight.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                  QUEUE_DEPTH = 4,
  parameter logic [ADDR_LEN-1:0] RESET_PC    = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                redirect,
  input  logic [ADDR_LEN-1:0] redirect_pc,
  output logic                imem_req,
  output logic [ADDR_LEN-1:0] imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [DATA_LEN-1:0] imem_rdata,
  output logic                out_valid,
  output logic [ADDR_LEN-1:0] out_pc,
  output logic [DATA_LEN-1:0] out_inst,
  input  logic                out_ready
);

  localparam int CNT_W   = $clog2(QUEUE_DEPTH) + 1;
  localparam int ENTRY_W = $bits(fetch_entry_t);

  fetch_state_e        state_q, state_d;
  logic [ADDR_LEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_LEN-1:0] resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]    outstanding_q, outstanding_d;
  logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
  logic                req_en_q;

  logic [CNT_W-1:0]    q_count;
  logic [CNT_W:0]      inflight;
  logic                credit_ok, grant, push, pop;
  fetch_entry_t        push_entry, head_entry;
  logic [ENTRY_W-1:0]  q_rdata;

  // Credit counts queued plus in-flight words; a same-cycle pop frees nothing yet.
  always_comb begin
    inflight  = {1'b0, q_count} + {1'b0, outstanding_q};
    credit_ok = inflight < (CNT_W + 1)'(QUEUE_DEPTH);
    imem_req  = req_en_q && (state_q == FETCH) && !redirect && credit_ok;
    grant     = imem_req && imem_gnt;
    push      = (state_q == FETCH) && !redirect && imem_rvalid;
    pop       = out_valid && out_ready && !redirect;
    push_entry.pc   = resp_pc_q;
    push_entry.inst = imem_rdata;
  end

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(imem_rvalid);
    if (redirect) begin
      fetch_pc_d = word_align(redirect_pc);
      resp_pc_d  = word_align(redirect_pc);
      // In FLUSH every in-flight word is already being dropped, so keep counting them.
      drop_cnt_d = (state_q == FETCH) ? outstanding_q - CNT_W'(imem_rvalid)
                                      : drop_cnt_q - CNT_W'(imem_rvalid);
      state_d    = (drop_cnt_d != '0) ? FLUSH : FETCH;
    end else if (state_q == FETCH) begin
      if (grant) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (push)  resp_pc_d  = resp_pc_q + PC_STEP;
    end else begin
      drop_cnt_d = drop_cnt_q - CNT_W'(imem_rvalid);
      if (drop_cnt_d == '0) state_d = FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      req_en_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      req_en_q      <= 1'b1;
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .valid (out_valid),
    .rdata (q_rdata),
    .count (q_count)
  );

  assign head_entry = q_rdata;
  assign out_pc     = head_entry.pc;
  assign out_inst   = head_entry.inst;
  assign imem_addr  = fetch_pc_q;

  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst)
    imem_rvalid |-> (outstanding_q != '0));

  a_outstanding_bound: assert property (@(posedge clk) disable iff (!rst)
    outstanding_q <= CNT_W'(QUEUE_DEPTH));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench: a memory model tags requests with a redirect epoch,
// current-epoch responses become expected decode outputs, and a monitor checks pops.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0, rst = 1'b1;
  logic        redirect = 1'b0, imem_gnt = 1'b0, imem_rvalid = 1'b0, out_ready = 1'b0;
  logic [31:0] redirect_pc = '0, imem_rdata = '0;
  logic        imem_req, out_valid;
  logic [31:0] imem_addr, out_pc, out_inst;

  fetch_unit #(.QUEUE_DEPTH(4), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int epoch; int ready; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;

  pend_t       pend[$];
  exp_t        sb[$];
  logic [31:0] popped[$];
  logic [31:0] grants[$];
  int          checks = 0, errors = 0, cyc = 0, epoch = 0, sb_new = 0;
  logic [31:0] mpc = RST_PC;
  int          p_gnt = 0, p_ready = 0, p_resp = 100, lat_extra = 0;
  bit          hold = 1'b0, mon_en = 1'b0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] at_or_bad(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hBAD0_BAD0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    sb.delete();
    epoch++;
    mpc    = RST_PC;
    sb_new = 0;
  endtask

  // One cycle of stimulus plus reference-model update.
  task automatic step(input bit redir, input logic [31:0] tgt);
    bit    stale, exp_req, got_resp;
    pend_t head, e;
    exp_t  x;
    @(negedge clk);
    cyc++;
    sb_new      = 0;
    redirect    = redir;
    redirect_pc = tgt;
    imem_gnt    = ($urandom_range(99) < p_gnt);
    out_ready   = ($urandom_range(99) < p_ready);
    got_resp    = !hold && (pend.size() > 0) && (pend[0].ready <= cyc) &&
                  ($urandom_range(99) < p_resp);
    imem_rvalid = got_resp;
    imem_rdata  = got_resp ? inst_of(pend[0].addr) : $urandom;
    #1;
    stale = 1'b0;
    foreach (pend[i]) if (pend[i].epoch != epoch) stale = 1'b1;
    exp_req = !redir && !stale && ((sb.size() + pend.size()) < 4);
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    if (imem_req && imem_gnt) begin
      chk("imem_addr", imem_addr, mpc);
      grants.push_back(imem_addr);
    end
    if (got_resp) begin
      head = pend.pop_front();
      if (!redir && head.epoch == epoch) begin
        x.pc   = head.addr;
        x.inst = inst_of(head.addr);
        sb.push_back(x);
        sb_new = 1;
      end
    end
    if (imem_req && imem_gnt) begin
      e.addr  = mpc;
      e.epoch = epoch;
      e.ready = cyc + 1 + int'($urandom_range(lat_extra));
      pend.push_back(e);
      mpc += 32'd4;
    end
    if (redir) begin
      epoch++;
      mpc = {tgt[31:2], 2'b00};
      sb.delete();
    end
  endtask

  task automatic drain();
    int n;
    p_gnt = 0; p_ready = 100; p_resp = 100; hold = 1'b0; lat_extra = 0;
    n = 0;
    while ((pend.size() != 0 || sb.size() != 0) && n < 60) begin
      step(1'b0, 32'h0);
      n++;
    end
    chk("drain_done", 32'(pend.size() + sb.size()), 32'd0);
  endtask

  // Monitor: compares every decode handshake against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en && rst && !redirect) begin
        chk("out_valid", 32'(out_valid), 32'((sb.size() - sb_new) > 0));
        if (out_valid && out_ready) begin
          popped.push_back(out_pc);
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_empty: got pc %h expected no output (cycle %0d)", out_pc, cyc);
          end else begin
            e = sb.pop_front();
            chk("out_pc", out_pc, e.pc);
            chk("out_inst", out_inst, e.inst);
          end
        end
      end
    end
  end

  initial begin
    int first_out, g0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_imem_req",  32'(imem_req),  32'd0);
    chk("rst_out_pc",    out_pc,         32'd0);
    chk("rst_out_inst",  out_inst,       32'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    mon_en = 1'b1;

    // Streaming from RESET_PC with a 1-cycle memory, including the address wrap.
    p_gnt = 100; p_ready = 100; p_resp = 100; lat_extra = 0; hold = 1'b0;
    grants.delete();
    first_out = -1;
    g0 = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 32'h0);
      if (first_out < 0 && out_valid) first_out = cyc;
    end
    chk("stream_grants", 32'(grants.size()), 32'd10);
    chk("wrap_addr0", at_or_bad(grants, 0), 32'hFFFF_FFF8);
    chk("wrap_addr1", at_or_bad(grants, 1), 32'hFFFF_FFFC);
    chk("wrap_addr2", at_or_bad(grants, 2), 32'h0000_0000);
    chk("wrap_addr3", at_or_bad(grants, 3), 32'h0000_0004);
    chk("first_out_lat", 32'(first_out - g0), 32'd2);

    // Decode stalled: exactly four grants fill the credit, then released in order.
    drain();
    p_gnt = 100; p_ready = 0;
    step(1'b1, 32'h0);
    grants.delete();
    repeat (12) step(1'b0, 32'h0);
    chk("full_grants", 32'(grants.size()), 32'd4);
    chk("full_req_low", 32'(imem_req), 32'd0);
    chk("full_head_pc", out_pc, 32'h0);
    popped.delete();
    p_ready = 100;
    repeat (8) step(1'b0, 32'h0);
    for (int i = 0; i < 4; i++) chk("full_order", at_or_bad(popped, i), 32'(i * 4));

    // Redirect with three words in flight: flush, then restart at the aligned target.
    drain();
    hold = 1'b1; p_gnt = 100;
    grants.delete();
    repeat (3) step(1'b0, 32'h0);
    chk("flush_outstanding", 32'(grants.size()), 32'd3);
    step(1'b1, 32'h0000_0103);
    hold = 1'b0;
    grants.delete();
    popped.delete();
    repeat (12) step(1'b0, 32'h0);
    chk("flush_next_addr", at_or_bad(grants, 0), 32'h0000_0100);
    chk("flush_first_pc",  at_or_bad(popped, 0), 32'h0000_0100);

    // Redirect coinciding with the only outstanding response: no flush needed.
    drain();
    hold = 1'b1; p_gnt = 100;
    step(1'b0, 32'h0);
    hold = 1'b0; p_gnt = 0;
    step(1'b1, 32'h0000_0040);
    p_gnt = 100;
    step(1'b0, 32'h0);
    chk("coinc_req",  32'(imem_req), 32'd1);
    chk("coinc_addr", imem_addr,     32'h0000_0040);

    // Randomized traffic with random latency, back-pressure and redirects.
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) begin
        p_gnt     = int'($urandom_range(30, 100));
        p_ready   = int'($urandom_range(20, 100));
        p_resp    = int'($urandom_range(30, 100));
        lat_extra = int'($urandom_range(0, 3));
      end
      step($urandom_range(99) < 3, $urandom);
    end

    // Reset in the middle of a full queue.
    drain();
    p_gnt = 100; p_ready = 0;
    repeat (10) step(1'b0, 32'h0);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect = 1'b0;
    #3 rst = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_imem_req",  32'(imem_req),  32'd0);
    chk("midrst_out_pc",    out_pc,         32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    p_ready = 100; p_gnt = 100; p_resp = 100; lat_extra = 0;
    grants.delete();
    repeat (6) step(1'b0, 32'h0);
    chk("restart_addr0", at_or_bad(grants, 0), RST_PC);
    chk("restart_addr1", at_or_bad(grants, 1), RST_PC + 32'd4);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
